sparc_exu_ecl_eccctl_gen: RTL and testbench
===========================================

# sparc_exu_ecl_eccctl_gen

Parametrised EXU register-file ECC control for `NUM_RS` source operands. It sits between the per-operand ECC checkers and the bypass/writeback logic. It qualifies correctable (CE) and uncorrectable (UE) errors in E and picks one CE operand to fix in M. It also keeps a sticky error log with overflow, a saturating CE counter with a storm threshold, and a one-shot/continuous error-injection FSM.

## Interface
Parameters:
- `NUM_RS`, 3: source operand count (≥2).
- `RS_W`, 5: register specifier width.
- `WIN_W`, 3: cwp/gl field width.
- `MASK_W`, 8: ECC injection mask width.
- `CNT_W`, 8: CE counter width.

Ports (one clock; reset is asynchronous and active-low):
- `clk` in 1: core clock.
- `arst_l` in 1: async active-low reset.
- `rst_tri_en` in 1: forces fix select to operand 0.
- `rs_sel_rf_d` in NUM_RS: D-stage bypass mux picked RF value.
- `rs_vld_e`, `ecc_ce_e`, `ecc_ue_e`, `cancel_e` in NUM_RS each: per-operand valid, checker CE, checker UE, ECC cancel.
- `inst_vld_e`, `disable_ce_e`, `nceen_e` in 1 each.
- `rs_m` in NUM_RS*RS_W: M-stage specifiers; operand i is at `[i*RS_W +: RS_W]`.
- `cwp_d` in WIN_W, `gl_e` in WIN_W-1.
- `spec_wen_next`, `inj_irferr`, `inj_oneshot` in 1 each.
- `ecc_mask` in MASK_W.
- `log_ack`, `ce_cnt_clr` in 1 each.
- `ce_thresh` in CNT_W.
- `rs_use_rf_e` out NUM_RS.
- `sel_ecc_m`, `ecc_ce_m`, `ecc_ue_m`, `ue_trap_m` out 1 each.
- `fix_sel_m_l` out NUM_RS: active-low, one-hot.
- `log_sel_m` out NUM_RS: one-hot.
- `fix_rd_m` out RS_W.
- `err_reg_m` out WIN_W+RS_W.
- `err_synd_7_m` out 1.
- `ecc_mask_m_l` out MASK_W.
- `inj_ack` out 1.
- `log_vld`, `log_ue`, `log_ovf`, `log_synd_7` out 1 each.
- `log_reg` out WIN_W+RS_W.
- `ce_cnt` out CNT_W, `ce_storm` out 1.

## Operation
- `rs_use_rf_e[i]` = flop(`rs_sel_rf_d[i]`) & `rs_vld_e[i]` & `inst_vld_e`.
- E qualification:
  - `ce_v[i]` = `ecc_ce_e[i]` & ~`cancel_e[i]` & `inst_vld_e`; `ue_v[i]` is formed the same way from `ecc_ue_e[i]`.
  - flag_ue = |ue_v | (|ce_v & disable_ce_e).
  - flag_ce = |ce_v & ~disable_ce_e.
- E→M flops: flag_ce→`sel_ecc_m`, flag_ue→`ecc_ue_m`, plus ce_v, ue_v, `nceen_e`, cwp (2 stages from D) and gl (1 stage from E).
- M outputs:
  - `ecc_ce_m` = `sel_ecc_m` & ~`ecc_ue_m`.
  - `ue_trap_m` = `ecc_ue_m` & nceen_m.
- Fix select: one-hot on the lowest index i with ce_m[i]; if none, index NUM_RS-1. `rst_tri_en`=1 forces index 0. `fix_rd_m` is that operand's `rs_m` slice.
- Log select: lowest UE index; else lowest CE index; else NUM_RS-1.
  - `err_reg_m` = {hi, rs}, where hi = {0,gl_m} if rs[RS_W-1:RS_W-2]==0, else cwp_m.
  - `err_synd_7_m` = ~ue_m[log idx].
- Error log (updates when `ecc_ce_m`|`ecc_ue_m`):
  - If ~`log_vld`: capture `err_reg_m`, `ecc_ue_m`, `err_synd_7_m`; set `log_vld`.
  - If `log_vld`: set `log_ovf`. A new UE overwrites a held CE; otherwise the held entry is kept.
  - `log_ack` clears `log_vld`/`log_ovf`. Ack coinciding with a new error: the new error is captured, `log_vld`=1, `log_ovf`=0.
- CE counter:
  - Increments on `ecc_ce_m` and saturates at all-ones.
  - `ce_storm` is set on the edge where the next count equals `ce_thresh`≠0. It stays sticky.
  - `ce_cnt_clr` clears the counter and storm, with priority over increment. `ce_thresh`=0 disables storm.
- Injection FSM, states IDLE/DONE:
  - inj_m = `spec_wen_next` & `inj_irferr` & (state==IDLE).
  - `ecc_mask_m_l` = ~(`ecc_mask` & {MASK_W{inj_m}}); `inj_ack` = flop(inj_m).
  - IDLE→DONE when inj_m & `inj_oneshot`. DONE→IDLE when ~`inj_irferr`.
  - With `inj_oneshot`=0, the FSM stays in IDLE.

## Timing
- E→M latency is 1 cycle for all flags and selects; log, counter, storm and `inj_ack` are 1 cycle after M.
- Reset values:
  - All flops 0; FSM in IDLE.
  - `sel_ecc_m`, `ecc_ce_m`, `ecc_ue_m`, `ue_trap_m`, `inj_ack`, `log_*`, `ce_cnt`, `ce_storm` = 0.
  - `fix_sel_m_l` = ~(1<<NUM_RS-1) (or ~1 with `rst_tri_en`); `log_sel_m` = 1<<NUM_RS-1; `err_synd_7_m`=1; `ecc_mask_m_l`=all-ones unless inj_m.
- Reset asserted mid-operation clears log, counter and FSM immediately, without waiting for a clock edge.
- `cancel_e` suppresses only its own operand in the same cycle.

## Test plan
- Operand 1 CE, operand 2 UE, nceen_e=1 → next cycle `ecc_ue_m`=1, `ue_trap_m`=1, `ecc_ce_m`=0, `log_sel_m`=3'b100, `fix_sel_m_l`=3'b101, `err_synd_7_m`=0.
- CE on operand 0 and operand 2, disable_ce_e=1 → `ecc_ue_m`=1, `sel_ecc_m`=0; log selects operand 0 and `log_ue`=1 one cycle later.
- Operand 0 CE with rs=5'd3, gl_e=2 → `err_reg_m`={3'b010,5'd3}. Operand 0 CE with rs=5'd17, cwp=5 → `err_reg_m`={3'b101,5'd17}.
- Three CEs, then a UE, then `log_ack` coinciding with a fourth CE → after the second CE `log_ovf`=1; after the UE `log_reg` holds the UE with `log_ue`=1; after the ack the fourth CE is held with `log_ovf`=0.
- ce_thresh=4, five CE cycles, then `ce_cnt_clr` coinciding with a CE → `ce_storm` rises after the 4th CE, `ce_cnt`=5; after the clr edge `ce_cnt`=0 and `ce_storm`=0. ce_thresh=0 → no storm at 255; the count saturates at 255.
- inj_oneshot=1, inj_irferr held, spec_wen_next pulsed 3× → exactly one `ecc_mask_m_l`=~ecc_mask cycle and one `inj_ack`. Dropping inj_irferr then re-asserting it re-arms injection. With inj_oneshot=0, all 3 pulses inject.

Source files
------------

// File: rtl/sparc_exu_ecl_eccctl_gen_if.sv
// Bundle of the E-stage checker inputs, M-stage fix/log outputs and the
// log/counter/injection controls of the EXU register-file ECC controller.
`timescale 1ns/1ps
interface sparc_exu_ecl_eccctl_gen_if #(
  parameter int NUM_RS = 3,
  parameter int RS_W   = 5,
  parameter int WIN_W  = 3,
  parameter int MASK_W = 8,
  parameter int CNT_W  = 8
) ();
  logic                    rst_tri_en;
  logic [NUM_RS-1:0]       rs_sel_rf_d;
  logic [NUM_RS-1:0]       rs_vld_e;
  logic [NUM_RS-1:0]       ecc_ce_e;
  logic [NUM_RS-1:0]       ecc_ue_e;
  logic [NUM_RS-1:0]       cancel_e;
  logic                    inst_vld_e;
  logic                    disable_ce_e;
  logic                    nceen_e;
  logic [NUM_RS*RS_W-1:0]  rs_m;
  logic [WIN_W-1:0]        cwp_d;
  logic [WIN_W-2:0]        gl_e;
  logic                    spec_wen_next;
  logic                    inj_irferr;
  logic                    inj_oneshot;
  logic [MASK_W-1:0]       ecc_mask;
  logic                    log_ack;
  logic                    ce_cnt_clr;
  logic [CNT_W-1:0]        ce_thresh;

  logic [NUM_RS-1:0]       rs_use_rf_e;
  logic                    sel_ecc_m;
  logic                    ecc_ce_m;
  logic                    ecc_ue_m;
  logic                    ue_trap_m;
  logic [NUM_RS-1:0]       fix_sel_m_l;
  logic [NUM_RS-1:0]       log_sel_m;
  logic [RS_W-1:0]         fix_rd_m;
  logic [WIN_W+RS_W-1:0]   err_reg_m;
  logic                    err_synd_7_m;
  logic [MASK_W-1:0]       ecc_mask_m_l;
  logic                    inj_ack;
  logic                    log_vld;
  logic                    log_ue;
  logic                    log_ovf;
  logic                    log_synd_7;
  logic [WIN_W+RS_W-1:0]   log_reg;
  logic [CNT_W-1:0]        ce_cnt;
  logic                    ce_storm;

  modport master (
    output rst_tri_en, rs_sel_rf_d, rs_vld_e, ecc_ce_e, ecc_ue_e, cancel_e,
           inst_vld_e, disable_ce_e, nceen_e, rs_m, cwp_d, gl_e,
           spec_wen_next, inj_irferr, inj_oneshot, ecc_mask,
           log_ack, ce_cnt_clr, ce_thresh,
    input  rs_use_rf_e, sel_ecc_m, ecc_ce_m, ecc_ue_m, ue_trap_m,
           fix_sel_m_l, log_sel_m, fix_rd_m, err_reg_m, err_synd_7_m,
           ecc_mask_m_l, inj_ack, log_vld, log_ue, log_ovf, log_synd_7,
           log_reg, ce_cnt, ce_storm
  );

  modport slave (
    input  rst_tri_en, rs_sel_rf_d, rs_vld_e, ecc_ce_e, ecc_ue_e, cancel_e,
           inst_vld_e, disable_ce_e, nceen_e, rs_m, cwp_d, gl_e,
           spec_wen_next, inj_irferr, inj_oneshot, ecc_mask,
           log_ack, ce_cnt_clr, ce_thresh,
    output rs_use_rf_e, sel_ecc_m, ecc_ce_m, ecc_ue_m, ue_trap_m,
           fix_sel_m_l, log_sel_m, fix_rd_m, err_reg_m, err_synd_7_m,
           ecc_mask_m_l, inj_ack, log_vld, log_ue, log_ovf, log_synd_7,
           log_reg, ce_cnt, ce_storm
  );
endinterface

// File: rtl/sparc_exu_ecl_eccctl_gen.sv
// EXU register-file ECC control: qualifies CE/UE in E, picks the operand to
// fix and the operand to log in M, keeps a sticky error log, a saturating CE
// counter with storm detect, and an error-injection sequencer.
//
// Injection FSM states:
//   state    | meaning
//   INJ_IDLE | armed; next write with inj_irferr gets the mask applied
//   INJ_DONE | one-shot used up; waits for inj_irferr to drop to re-arm
`timescale 1ns/1ps
module sparc_exu_ecl_eccctl_gen #(
  parameter int NUM_RS = 3,
  parameter int RS_W   = 5,
  parameter int WIN_W  = 3,
  parameter int MASK_W = 8,
  parameter int CNT_W  = 8
) (
  input logic clk,
  input logic arst_l,
  sparc_exu_ecl_eccctl_gen_if.slave bus
);
  localparam int ERR_W = WIN_W + RS_W;

  typedef enum logic {INJ_IDLE = 1'b0, INJ_DONE = 1'b1} inj_state_e;

  logic [NUM_RS-1:0] rs_sel_rf_e;
  logic [NUM_RS-1:0] ce_v, ue_v, ce_m, ue_m;
  logic              flag_ce, flag_ue;
  logic              sel_ecc_m, ecc_ue_m, nceen_m, ecc_ce_m;
  logic [WIN_W-1:0]  cwp_e, cwp_m;
  logic [WIN_W-2:0]  gl_m;
  logic [NUM_RS-1:0] fix_oh, log_oh;
  logic [RS_W-1:0]   fix_rd, log_rs;
  logic [WIN_W-1:0]  err_hi;
  logic [ERR_W-1:0]  err_reg_m;
  logic              err_synd_7_m;
  logic              log_upd;
  logic              log_vld, log_ue, log_ovf, log_synd_7;
  logic [ERR_W-1:0]  log_reg;
  logic [CNT_W-1:0]  ce_cnt, ce_cnt_nxt;
  logic              ce_storm;
  inj_state_e        inj_state;
  logic              inj_m, inj_ack;

  // E-stage error qualification: cancel only masks its own operand
  always_comb begin
    ce_v    = bus.ecc_ce_e & ~bus.cancel_e & {NUM_RS{bus.inst_vld_e}};
    ue_v    = bus.ecc_ue_e & ~bus.cancel_e & {NUM_RS{bus.inst_vld_e}};
    flag_ue = (|ue_v) | ((|ce_v) & bus.disable_ce_e);
    flag_ce = (|ce_v) & ~bus.disable_ce_e;
  end

  // D->E and E->M pipeline flops
  always_ff @(posedge clk or negedge arst_l) begin
    if (!arst_l) begin
      rs_sel_rf_e <= '0;
      sel_ecc_m   <= 1'b0;
      ecc_ue_m    <= 1'b0;
      ce_m        <= '0;
      ue_m        <= '0;
      nceen_m     <= 1'b0;
      cwp_e       <= '0;
      cwp_m       <= '0;
      gl_m        <= '0;
    end else begin
      rs_sel_rf_e <= bus.rs_sel_rf_d;
      sel_ecc_m   <= flag_ce;
      ecc_ue_m    <= flag_ue;
      ce_m        <= ce_v;
      ue_m        <= ue_v;
      nceen_m     <= bus.nceen_e;
      cwp_e       <= bus.cwp_d;
      cwp_m       <= cwp_e;
      gl_m        <= bus.gl_e;
    end
  end

  // M-stage fix/log operand selection; lowest index wins, last operand is the default
  always_comb begin
    fix_oh = '0;
    fix_oh[NUM_RS-1] = 1'b1;
    for (int i = NUM_RS - 1; i >= 0; i--) begin
      if (ce_m[i]) begin
        fix_oh    = '0;
        fix_oh[i] = 1'b1;
      end
    end
    if (bus.rst_tri_en) fix_oh = NUM_RS'(1);

    log_oh = '0;
    log_oh[NUM_RS-1] = 1'b1;
    for (int i = NUM_RS - 1; i >= 0; i--) begin
      if (ce_m[i]) begin
        log_oh    = '0;
        log_oh[i] = 1'b1;
      end
    end
    // a UE anywhere outranks every CE
    for (int i = NUM_RS - 1; i >= 0; i--) begin
      if (ue_m[i]) begin
        log_oh    = '0;
        log_oh[i] = 1'b1;
      end
    end

    fix_rd = '0;
    log_rs = '0;
    for (int i = 0; i < NUM_RS; i++) begin
      fix_rd = fix_rd | (bus.rs_m[i*RS_W +: RS_W] & {RS_W{fix_oh[i]}});
      log_rs = log_rs | (bus.rs_m[i*RS_W +: RS_W] & {RS_W{log_oh[i]}});
    end

    // globals live in the low register range, windowed regs carry the cwp
    err_hi       = (log_rs[RS_W-1 -: 2] == 2'b00) ? {1'b0, gl_m} : cwp_m;
    err_reg_m    = {err_hi, log_rs};
    err_synd_7_m = ~(|(ue_m & log_oh));
    ecc_ce_m     = sel_ecc_m & ~ecc_ue_m;
    log_upd      = ecc_ce_m | ecc_ue_m;
    ce_cnt_nxt   = (ce_cnt == {CNT_W{1'b1}}) ? ce_cnt : ce_cnt + CNT_W'(1);
    inj_m        = bus.spec_wen_next & bus.inj_irferr & (inj_state == INJ_IDLE);
  end

  // sticky error log; ack with a simultaneous error restarts the log on that error
  always_ff @(posedge clk or negedge arst_l) begin
    if (!arst_l) begin
      log_vld    <= 1'b0;
      log_ue     <= 1'b0;
      log_ovf    <= 1'b0;
      log_synd_7 <= 1'b0;
      log_reg    <= '0;
    end else if (bus.log_ack) begin
      log_vld <= log_upd;
      log_ovf <= 1'b0;
      if (log_upd) begin
        log_reg    <= err_reg_m;
        log_ue     <= ecc_ue_m;
        log_synd_7 <= err_synd_7_m;
      end
    end else if (log_upd) begin
      if (!log_vld) begin
        log_vld    <= 1'b1;
        log_reg    <= err_reg_m;
        log_ue     <= ecc_ue_m;
        log_synd_7 <= err_synd_7_m;
      end else begin
        log_ovf <= 1'b1;
        if (ecc_ue_m && !log_ue) begin
          log_reg    <= err_reg_m;
          log_ue     <= 1'b1;
          log_synd_7 <= err_synd_7_m;
        end
      end
    end
  end

  // saturating CE counter with sticky storm flag; clear beats increment
  always_ff @(posedge clk or negedge arst_l) begin
    if (!arst_l) begin
      ce_cnt   <= '0;
      ce_storm <= 1'b0;
    end else if (bus.ce_cnt_clr) begin
      ce_cnt   <= '0;
      ce_storm <= 1'b0;
    end else if (ecc_ce_m) begin
      ce_cnt <= ce_cnt_nxt;
      if ((bus.ce_thresh != '0) && (ce_cnt_nxt == bus.ce_thresh)) ce_storm <= 1'b1;
    end
  end

  // injection sequencer and its registered acknowledge
  always_ff @(posedge clk or negedge arst_l) begin
    if (!arst_l) begin
      inj_state <= INJ_IDLE;
      inj_ack   <= 1'b0;
    end else begin
      inj_ack <= inj_m;
      case (inj_state)
        INJ_IDLE: if (inj_m && bus.inj_oneshot) inj_state <= INJ_DONE;
        INJ_DONE: if (!bus.inj_irferr) inj_state <= INJ_IDLE;
        default:  inj_state <= INJ_IDLE;
      endcase
    end
  end

  assign bus.rs_use_rf_e  = rs_sel_rf_e & bus.rs_vld_e & {NUM_RS{bus.inst_vld_e}};
  assign bus.sel_ecc_m    = sel_ecc_m;
  assign bus.ecc_ce_m     = ecc_ce_m;
  assign bus.ecc_ue_m     = ecc_ue_m;
  assign bus.ue_trap_m    = ecc_ue_m & nceen_m;
  assign bus.fix_sel_m_l  = ~fix_oh;
  assign bus.log_sel_m    = log_oh;
  assign bus.fix_rd_m     = fix_rd;
  assign bus.err_reg_m    = err_reg_m;
  assign bus.err_synd_7_m = err_synd_7_m;
  assign bus.ecc_mask_m_l = ~(bus.ecc_mask & {MASK_W{inj_m}});
  assign bus.inj_ack      = inj_ack;
  assign bus.log_vld      = log_vld;
  assign bus.log_ue       = log_ue;
  assign bus.log_ovf      = log_ovf;
  assign bus.log_synd_7   = log_synd_7;
  assign bus.log_reg      = log_reg;
  assign bus.ce_cnt       = ce_cnt;
  assign bus.ce_storm     = ce_storm;
endmodule

// File: tb/tb_sparc_exu_ecl_eccctl_gen.sv
// Scoreboard bench for the ECC controller: stimulus pushes expected values
// tagged with the cycle they must appear in; a negedge monitor compares them.
`timescale 1ns/1ps
module tb_sparc_exu_ecl_eccctl_gen;
  localparam int F_SEL_ECC = 0,  F_ECC_CE = 1,  F_ECC_UE = 2,  F_UE_TRAP = 3;
  localparam int F_FIX_L   = 4,  F_LOG_SEL = 5, F_FIX_RD = 6,  F_ERR_REG = 7;
  localparam int F_SYND7   = 8,  F_MASK_L = 9,  F_INJ_ACK = 10, F_LOG_VLD = 11;
  localparam int F_LOG_UE  = 12, F_LOG_OVF = 13, F_LOG_SY7 = 14, F_LOG_REG = 15;
  localparam int F_CE_CNT  = 16, F_STORM = 17,  F_USE_RF = 18;

  typedef struct {
    int          cyc;
    int          fld;
    logic [31:0] exp;
    string       nm;
  } exp_t;

  logic clk = 1'b0;
  logic arst_l = 1'b0;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_fail = 0;
  exp_t sb[$];

  sparc_exu_ecl_eccctl_gen_if #(.NUM_RS(3), .RS_W(5), .WIN_W(3), .MASK_W(8), .CNT_W(8)) bus ();

  sparc_exu_ecl_eccctl_gen #(.NUM_RS(3), .RS_W(5), .WIN_W(3), .MASK_W(8), .CNT_W(8)) dut (
    .clk    (clk),
    .arst_l (arst_l),
    .bus    (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] field(int f);
    case (f)
      F_SEL_ECC: return 32'(bus.sel_ecc_m);
      F_ECC_CE:  return 32'(bus.ecc_ce_m);
      F_ECC_UE:  return 32'(bus.ecc_ue_m);
      F_UE_TRAP: return 32'(bus.ue_trap_m);
      F_FIX_L:   return 32'(bus.fix_sel_m_l);
      F_LOG_SEL: return 32'(bus.log_sel_m);
      F_FIX_RD:  return 32'(bus.fix_rd_m);
      F_ERR_REG: return 32'(bus.err_reg_m);
      F_SYND7:   return 32'(bus.err_synd_7_m);
      F_MASK_L:  return 32'(bus.ecc_mask_m_l);
      F_INJ_ACK: return 32'(bus.inj_ack);
      F_LOG_VLD: return 32'(bus.log_vld);
      F_LOG_UE:  return 32'(bus.log_ue);
      F_LOG_OVF: return 32'(bus.log_ovf);
      F_LOG_SY7: return 32'(bus.log_synd_7);
      F_LOG_REG: return 32'(bus.log_reg);
      F_CE_CNT:  return 32'(bus.ce_cnt);
      F_STORM:   return 32'(bus.ce_storm);
      F_USE_RF:  return 32'(bus.rs_use_rf_e);
      default:   return 32'hDEAD_BEEF;
    endcase
  endfunction

  task automatic push_exp(input int dcyc, input int f, input logic [31:0] v, input string nm);
    exp_t e;
    e.cyc = cyc + dcyc;
    e.fld = f;
    e.exp = v;
    e.nm  = nm;
    sb.push_back(e);
  endtask

  // monitor: compare everything due this cycle
  always @(negedge clk) begin
    logic [31:0] got;
    for (int j = sb.size() - 1; j >= 0; j--) begin
      if (sb[j].cyc == cyc) begin
        got = field(sb[j].fld);
        n_cmp++;
        if (got !== sb[j].exp) begin
          n_fail++;
          $display("FAIL %s @cyc %0d: got %0h, expected %0h", sb[j].nm, cyc, got, sb[j].exp);
        end
        sb.delete(j);
      end
    end
  end

  task automatic clr_in();
    bus.rst_tri_en    = 1'b0;
    bus.rs_vld_e      = '0;
    bus.ecc_ce_e      = '0;
    bus.ecc_ue_e      = '0;
    bus.cancel_e      = '0;
    bus.inst_vld_e    = 1'b0;
    bus.disable_ce_e  = 1'b0;
    bus.nceen_e       = 1'b0;
    bus.spec_wen_next = 1'b0;
    bus.log_ack       = 1'b0;
    bus.ce_cnt_clr    = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    clr_in();
  endtask

  task automatic ce1();
    bus.inst_vld_e = 1'b1;
    bus.ecc_ce_e   = 3'b010;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    clr_in();
    bus.rs_sel_rf_d = 3'b101;
    bus.rs_m        = {5'd20, 5'd17, 5'd3};
    bus.cwp_d       = 3'd5;
    bus.gl_e        = 2'd2;
    bus.inj_irferr  = 1'b0;
    bus.inj_oneshot = 1'b0;
    bus.ecc_mask    = 8'h5A;
    bus.ce_thresh   = 8'd0;

    // reset values
    step(); step();
    push_exp(0, F_LOG_VLD, 0, "rst log_vld");
    push_exp(0, F_CE_CNT, 0, "rst ce_cnt");
    step();
    arst_l = 1'b1;
    step();
    push_exp(0, F_SEL_ECC, 0, "rst sel_ecc_m");
    push_exp(0, F_ECC_UE, 0, "rst ecc_ue_m");
    push_exp(0, F_FIX_L, 3'b011, "rst fix_sel_m_l");
    push_exp(0, F_LOG_SEL, 3'b100, "rst log_sel_m");
    push_exp(0, F_SYND7, 1, "rst err_synd_7_m");
    push_exp(0, F_MASK_L, 8'hFF, "rst ecc_mask_m_l");
    push_exp(0, F_INJ_ACK, 0, "rst inj_ack");
    push_exp(0, F_STORM, 0, "rst ce_storm");
    step();
    bus.rst_tri_en = 1'b1;
    push_exp(0, F_FIX_L, 3'b110, "rst fix_sel_m_l tri");
    step(); step();

    // op1 CE, op2 UE, nceen
    step();
    bus.rs_vld_e = 3'b111; bus.inst_vld_e = 1'b1;
    bus.ecc_ce_e = 3'b010; bus.ecc_ue_e = 3'b100; bus.nceen_e = 1'b1;
    bus.rs_sel_rf_d = 3'b011;
    push_exp(0, F_USE_RF, 3'b101, "t1 rs_use_rf_e");
    push_exp(1, F_SEL_ECC, 1, "t1 sel_ecc_m");
    push_exp(1, F_ECC_UE, 1, "t1 ecc_ue_m");
    push_exp(1, F_UE_TRAP, 1, "t1 ue_trap_m");
    push_exp(1, F_ECC_CE, 0, "t1 ecc_ce_m");
    push_exp(1, F_LOG_SEL, 3'b100, "t1 log_sel_m");
    push_exp(1, F_FIX_L, 3'b101, "t1 fix_sel_m_l");
    push_exp(1, F_SYND7, 0, "t1 err_synd_7_m");
    push_exp(1, F_FIX_RD, 17, "t1 fix_rd_m");
    push_exp(1, F_ERR_REG, 8'hB4, "t1 err_reg_m");
    push_exp(2, F_LOG_VLD, 1, "t1 log_vld");
    push_exp(2, F_LOG_UE, 1, "t1 log_ue");
    push_exp(2, F_LOG_REG, 8'hB4, "t1 log_reg");
    push_exp(2, F_LOG_SY7, 0, "t1 log_synd_7");
    push_exp(2, F_LOG_OVF, 0, "t1 log_ovf");
    push_exp(2, F_CE_CNT, 0, "t1 ce_cnt");
    step();
    bus.rs_vld_e = 3'b111; bus.inst_vld_e = 1'b1;
    push_exp(0, F_USE_RF, 3'b011, "t1b rs_use_rf_e");
    step();
    bus.rs_vld_e = 3'b111;
    push_exp(0, F_USE_RF, 3'b000, "t1c rs_use_rf_e");
    step();
    bus.log_ack = 1'b1;
    push_exp(1, F_LOG_VLD, 0, "t1 ack log_vld");
    step();

    // CE on op0 and op2 with CE handling disabled
    step();
    bus.inst_vld_e = 1'b1; bus.ecc_ce_e = 3'b101; bus.disable_ce_e = 1'b1;
    push_exp(1, F_ECC_UE, 1, "t2 ecc_ue_m");
    push_exp(1, F_SEL_ECC, 0, "t2 sel_ecc_m");
    push_exp(1, F_UE_TRAP, 0, "t2 ue_trap_m");
    push_exp(1, F_LOG_SEL, 3'b001, "t2 log_sel_m");
    push_exp(1, F_FIX_L, 3'b110, "t2 fix_sel_m_l");
    push_exp(1, F_ERR_REG, 8'h43, "t2 err_reg_m gl");
    push_exp(1, F_SYND7, 1, "t2 err_synd_7_m");
    push_exp(2, F_LOG_VLD, 1, "t2 log_vld");
    push_exp(2, F_LOG_UE, 1, "t2 log_ue");
    push_exp(2, F_LOG_REG, 8'h43, "t2 log_reg");
    step(); step();
    bus.log_ack = 1'b1;
    step();

    // cancel masks op0 only; rst_tri_en overrides fix select
    step();
    bus.inst_vld_e = 1'b1; bus.ecc_ce_e = 3'b011; bus.cancel_e = 3'b001;
    push_exp(1, F_ECC_CE, 1, "t3 ecc_ce_m");
    push_exp(1, F_LOG_SEL, 3'b010, "t3 log_sel_m");
    push_exp(1, F_ERR_REG, 8'hB1, "t3 err_reg_m cwp");
    push_exp(2, F_CE_CNT, 1, "t3 ce_cnt");
    push_exp(2, F_LOG_REG, 8'hB1, "t3 log_reg");
    push_exp(2, F_LOG_UE, 0, "t3 log_ue");
    step();
    bus.rst_tri_en = 1'b1;
    push_exp(0, F_FIX_L, 3'b110, "t3 fix_sel_m_l tri");
    push_exp(0, F_FIX_RD, 3, "t3 fix_rd_m tri");
    step();
    bus.log_ack = 1'b1;
    step();

    // log overflow, UE overwrite, ack with coincident CE
    step(); ce1();
    push_exp(2, F_LOG_VLD, 1, "t4 log_vld ce1");
    push_exp(2, F_LOG_OVF, 0, "t4 log_ovf ce1");
    step(); ce1();
    push_exp(2, F_LOG_OVF, 1, "t4 log_ovf ce2");
    push_exp(2, F_LOG_REG, 8'hB1, "t4 log_reg ce2");
    step(); ce1();
    step();
    bus.inst_vld_e = 1'b1; bus.ecc_ue_e = 3'b100;
    push_exp(2, F_LOG_REG, 8'hB4, "t4 log_reg ue");
    push_exp(2, F_LOG_UE, 1, "t4 log_ue ue");
    push_exp(2, F_LOG_SY7, 0, "t4 log_synd_7 ue");
    push_exp(2, F_LOG_OVF, 1, "t4 log_ovf ue");
    step();
    step(); ce1();
    step();
    bus.log_ack = 1'b1;
    push_exp(1, F_LOG_VLD, 1, "t4 ack log_vld");
    push_exp(1, F_LOG_OVF, 0, "t4 ack log_ovf");
    push_exp(1, F_LOG_REG, 8'hB1, "t4 ack log_reg");
    push_exp(1, F_LOG_UE, 0, "t4 ack log_ue");
    push_exp(1, F_LOG_SY7, 1, "t4 ack log_synd_7");
    step(); step();

    // CE storm at threshold 4, then clear coinciding with a CE
    step();
    bus.ce_thresh = 8'd4; bus.ce_cnt_clr = 1'b1;
    push_exp(1, F_CE_CNT, 0, "t5 clr ce_cnt");
    for (int i = 0; i < 6; i++) begin
      step(); ce1();
      if (i < 5) begin
        push_exp(2, F_CE_CNT, 32'(i + 1), "t5 ce_cnt");
        push_exp(2, F_STORM, (i >= 3) ? 32'd1 : 32'd0, "t5 ce_storm");
      end
    end
    step();
    bus.ce_cnt_clr = 1'b1;
    push_exp(1, F_CE_CNT, 0, "t5 clr2 ce_cnt");
    push_exp(1, F_STORM, 0, "t5 clr2 ce_storm");
    step();

    // saturation with storm disabled
    step();
    bus.ce_thresh = 8'd0; bus.ce_cnt_clr = 1'b1;
    for (int i = 0; i < 260; i++) begin
      step(); ce1();
      if (i == 253) push_exp(2, F_CE_CNT, 254, "t6 ce_cnt 254");
      if (i == 254) push_exp(2, F_CE_CNT, 255, "t6 ce_cnt 255");
      if (i == 259) begin
        push_exp(2, F_CE_CNT, 255, "t6 ce_cnt sat");
        push_exp(2, F_STORM, 0, "t6 ce_storm off");
      end
    end
    step(); step();

    // one-shot injection
    step();
    bus.inj_irferr = 1'b1; bus.inj_oneshot = 1'b1;
    push_exp(0, F_MASK_L, 8'hFF, "t7 mask idle");
    step(); bus.spec_wen_next = 1'b1;
    push_exp(0, F_MASK_L, 8'hA5, "t7 mask p1");
    push_exp(1, F_INJ_ACK, 1, "t7 ack p1");
    step();
    push_exp(0, F_MASK_L, 8'hFF, "t7 mask gap");
    push_exp(1, F_INJ_ACK, 0, "t7 ack gap");
    step(); bus.spec_wen_next = 1'b1;
    push_exp(0, F_MASK_L, 8'hFF, "t7 mask p2");
    push_exp(1, F_INJ_ACK, 0, "t7 ack p2");
    step();
    step(); bus.spec_wen_next = 1'b1;
    push_exp(0, F_MASK_L, 8'hFF, "t7 mask p3");
    push_exp(1, F_INJ_ACK, 0, "t7 ack p3");
    step(); bus.inj_irferr = 1'b0;
    step(); bus.inj_irferr = 1'b1; bus.spec_wen_next = 1'b1;
    push_exp(0, F_MASK_L, 8'hA5, "t7 mask rearm");
    push_exp(1, F_INJ_ACK, 1, "t7 ack rearm");
    step(); bus.inj_irferr = 1'b0; bus.inj_oneshot = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step(); bus.inj_irferr = 1'b1; bus.spec_wen_next = 1'b1;
      push_exp(0, F_MASK_L, 8'hA5, "t8 mask cont");
      push_exp(1, F_INJ_ACK, 1, "t8 ack cont");
      step();
    end
    bus.inj_irferr = 1'b0;

    // asynchronous reset mid-operation
    step(); ce1();
    push_exp(2, F_LOG_VLD, 1, "t9 log_vld pre");
    push_exp(2, F_CE_CNT, 255, "t9 ce_cnt pre");
    step(); step();
    step();
    arst_l = 1'b0;
    push_exp(0, F_LOG_VLD, 0, "t9 async log_vld");
    push_exp(0, F_CE_CNT, 0, "t9 async ce_cnt");
    push_exp(0, F_LOG_OVF, 0, "t9 async log_ovf");
    step();
    arst_l = 1'b1;
    step(); step(); step();

    n_cmp++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard drain: %0d entries left, expected 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
